// File: rtl/stg0ia_pkg.sv
// Shared sizes, state encodings and PC helper for the instruction-address stage.
package stg0ia_pkg;

  localparam int unsigned SIZE_ADDR = 32;
  localparam int unsigned HBIT_ADDR = SIZE_ADDR - 1;
  localparam int unsigned CNT_W     = 4;

  typedef logic [HBIT_ADDR:0] addr_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  // State encodings are fixed so they read the same in waveforms and debug taps.
  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_BUBBLE = 2'd2,
    S_HALT   = 2'd3
  } state_e;

  // Word-addressed sequential advance; all-ones wraps silently to zero.
  function automatic addr_t pc_inc(input addr_t pc);
    return pc + addr_t'(1);
  endfunction

endpackage

// File: rtl/stg0ia_cnt.sv
// Loadable down-counter with enable and an "equals one" flag, shared by BOOT and BUBBLE.
module stg0ia_cnt
  import stg0ia_pkg::*;
#(
  parameter cnt_t RESET_VAL = cnt_t'(2)
) (
  input  logic iw_clk,
  input  logic iw_rst,
  input  logic iw_load,
  input  cnt_t iw_load_val,
  input  logic iw_en,
  output logic ow_one_c
);

  cnt_t cnt_q;
  cnt_t cnt_d;

  // Load wins over decrement; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (iw_load) begin
      cnt_d = iw_load_val;
    end else if (iw_en && (cnt_q != cnt_t'(0))) begin
      cnt_d = cnt_q - cnt_t'(1);
    end
  end

  // Counter register, reloaded with the boot delay on reset.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      cnt_q <= RESET_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ow_one_c = (cnt_q == cnt_t'(1));

endmodule

// File: rtl/stg0ia.sv
// Instruction-address stage: owns the PC and decides each cycle whether the fetch is valid.
module stg0ia
  import stg0ia_pkg::*;
#(
  parameter addr_t       RESET_PC       = '0,
  parameter int unsigned BOOT_DELAY     = 2,
  parameter int unsigned BRANCH_BUBBLES = 1
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_stall,
  input  logic              iw_branch_taken,
  input  logic [HBIT_ADDR:0] iw_branch_pc,
  input  logic              iw_halt,
  input  logic              iw_resume,
  output logic [HBIT_ADDR:0] ow_pc,
  output logic              ow_ia_valid,
  output logic              ow_halted
);

  state_e state_q, state_d;
  addr_t  pc_q, pc_d;
  logic   valid_q, valid_d;
  logic   halted_q, halted_d;

  logic   cnt_load;
  logic   cnt_en;
  logic   cnt_one;

  // Boot delay and branch bubbles share one counter; reset preloads the boot delay.
  stg0ia_cnt #(
    .RESET_VAL(cnt_t'(BOOT_DELAY))
  ) u_cnt (
    .iw_clk     (iw_clk),
    .iw_rst     (iw_rst),
    .iw_load    (cnt_load),
    .iw_load_val(cnt_t'(BRANCH_BUBBLES)),
    .iw_en      (cnt_en),
    .ow_one_c   (cnt_one)
  );

  // Next-state, next-PC and next-output decode; priority is branch/halt > stall > advance.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;

    case (state_q)
      S_BOOT: begin
        valid_d = 1'b0;
        cnt_en  = 1'b1;
        if (cnt_one) begin
          state_d = S_RUN;
          valid_d = 1'b1;
        end
      end

      S_RUN: begin
        if (iw_halt) begin
          state_d  = S_HALT;
          valid_d  = 1'b0;
          halted_d = 1'b1;
          if (iw_branch_taken) begin
            pc_d = iw_branch_pc;
          end else if (!iw_stall) begin
            pc_d = pc_inc(pc_q);
          end
        end else if (iw_branch_taken) begin
          pc_d = iw_branch_pc;
          if (BRANCH_BUBBLES == 0) begin
            valid_d = 1'b1;
          end else begin
            valid_d  = 1'b0;
            cnt_load = 1'b1;
            state_d  = S_BUBBLE;
          end
        end else if (!iw_stall) begin
          pc_d = pc_inc(pc_q);
        end
      end

      S_BUBBLE: begin
        valid_d = 1'b0;
        if (iw_halt) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          if (iw_branch_taken) begin
            pc_d = iw_branch_pc;
          end
        end else if (iw_branch_taken) begin
          pc_d     = iw_branch_pc;
          cnt_load = 1'b1;
        end else if (!iw_stall) begin
          if (cnt_one) begin
            state_d = S_RUN;
            valid_d = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end

      S_HALT: begin
        valid_d = 1'b0;
        if (iw_branch_taken) begin
          pc_d = iw_branch_pc;
        end
        if (iw_resume) begin
          state_d  = S_RUN;
          valid_d  = 1'b1;
          halted_d = 1'b0;
        end
      end

      default: begin
        state_d  = S_BOOT;
        valid_d  = 1'b0;
        halted_d = 1'b0;
      end
    endcase
  end

  // State, PC and output registers.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign ow_pc       = pc_q;
  assign ow_ia_valid = valid_q;
  assign ow_halted   = halted_q;

endmodule

// File: tb/tb_stg0ia.sv
// Directed bench for stg0ia: one instance with a 1-cycle branch bubble, one with none.
module tb_stg0ia;
  import stg0ia_pkg::*;

  logic  clk;
  logic  rst;

  logic  a_stall, a_branch, a_halt, a_resume;
  addr_t a_bpc, a_pc;
  logic  a_valid, a_halted;

  logic  b_stall, b_branch, b_halt, b_resume;
  addr_t b_bpc, b_pc;
  logic  b_valid, b_halted;

  int    n_vec;
  int    n_err;

  stg0ia #(
    .RESET_PC      (addr_t'(32'h10)),
    .BOOT_DELAY    (2),
    .BRANCH_BUBBLES(1)
  ) u_a (
    .iw_clk         (clk),
    .iw_rst         (rst),
    .iw_stall       (a_stall),
    .iw_branch_taken(a_branch),
    .iw_branch_pc   (a_bpc),
    .iw_halt        (a_halt),
    .iw_resume      (a_resume),
    .ow_pc          (a_pc),
    .ow_ia_valid    (a_valid),
    .ow_halted      (a_halted)
  );

  stg0ia #(
    .RESET_PC      (addr_t'(0)),
    .BOOT_DELAY    (1),
    .BRANCH_BUBBLES(0)
  ) u_b (
    .iw_clk         (clk),
    .iw_rst         (rst),
    .iw_stall       (b_stall),
    .iw_branch_taken(b_branch),
    .iw_branch_pc   (b_bpc),
    .iw_halt        (b_halt),
    .iw_resume      (b_resume),
    .ow_pc          (b_pc),
    .ow_ia_valid    (b_valid),
    .ow_halted      (b_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
  endtask

  task automatic chk_a(input string tag, input addr_t pc, input logic v, input logic h);
    chk({tag, ".pc"}, 64'(a_pc), 64'(pc));
    chk({tag, ".valid"}, 64'(a_valid), 64'(v));
    chk({tag, ".halted"}, 64'(a_halted), 64'(h));
  endtask

  task automatic chk_b(input string tag, input addr_t pc, input logic v, input logic h);
    chk({tag, ".pc"}, 64'(b_pc), 64'(pc));
    chk({tag, ".valid"}, 64'(b_valid), 64'(v));
    chk({tag, ".halted"}, 64'(b_halted), 64'(h));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    {a_stall, a_branch, a_halt, a_resume} = '0;
    {b_stall, b_branch, b_halt, b_resume} = '0;
    a_bpc = '0;
    b_bpc = '0;

    // Reset held.
    tick();
    tick();
    chk_a("a_reset", 32'h10, 1'b0, 1'b0);
    chk_b("b_reset", 32'h0, 1'b0, 1'b0);

    // Release between edges; A waits two invalid cycles, B one.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_a("a_boot0", 32'h10, 1'b0, 1'b0);
    tick();
    chk_a("a_boot1", 32'h10, 1'b0, 1'b0);
    chk_b("b_boot_done", 32'h0, 1'b1, 1'b0);
    tick();
    chk_a("a_first", 32'h10, 1'b1, 1'b0);
    tick();
    chk_a("a_seq1", 32'h11, 1'b1, 1'b0);
    tick();
    chk_a("a_seq2", 32'h12, 1'b1, 1'b0);

    // Advance to 0x20 and stall three cycles.
    for (int i = 0; i < 14; i++) tick();
    chk_a("a_at20", 32'h20, 1'b1, 1'b0);
    a_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("a_stall", 32'h20, 1'b1, 1'b0);
    end
    a_stall = 1'b0;
    tick();
    chk_a("a_unstall", 32'h21, 1'b1, 1'b0);

    // Get to pc 0x05, then branch to 0x80 with one bubble.
    a_branch = 1'b1;
    a_bpc    = 32'h05;
    tick();
    chk_a("a_to05_bub", 32'h05, 1'b0, 1'b0);
    a_branch = 1'b0;
    tick();
    chk_a("a_at05", 32'h05, 1'b1, 1'b0);
    a_branch = 1'b1;
    a_bpc    = 32'h80;
    tick();
    chk_a("a_br80_bub", 32'h80, 1'b0, 1'b0);
    a_branch = 1'b0;
    tick();
    chk_a("a_br80_fetch", 32'h80, 1'b1, 1'b0);
    tick();
    chk_a("a_br80_next", 32'h81, 1'b1, 1'b0);

    // B: branch concurrent with stall, no bubble configured.
    b_stall  = 1'b1;
    b_branch = 1'b1;
    b_bpc    = 32'h40;
    tick();
    chk_b("b_br40", 32'h40, 1'b1, 1'b0);
    b_branch = 1'b0;
    tick();
    chk_b("b_br40_stall", 32'h40, 1'b1, 1'b0);
    b_stall = 1'b0;
    tick();
    chk_b("b_br40_next", 32'h41, 1'b1, 1'b0);

    // B: halt from RUN, then resume together with a branch (no bubble).
    b_halt = 1'b1;
    tick();
    chk_b("b_halt", 32'h42, 1'b0, 1'b1);
    b_halt   = 1'b0;
    b_resume = 1'b1;
    b_branch = 1'b1;
    b_bpc    = 32'h99;
    tick();
    chk_b("b_resume_br", 32'h99, 1'b1, 1'b0);
    b_resume = 1'b0;
    b_branch = 1'b0;
    tick();
    chk_b("b_resume_next", 32'h9a, 1'b1, 1'b0);

    // A: reach 0x30, halt unstalled, resume five cycles later.
    a_branch = 1'b1;
    a_bpc    = 32'h30;
    tick();
    a_branch = 1'b0;
    tick();
    chk_a("a_at30", 32'h30, 1'b1, 1'b0);
    a_halt = 1'b1;
    tick();
    chk_a("a_halt", 32'h31, 1'b0, 1'b1);
    a_halt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_a("a_halt_hold", 32'h31, 1'b0, 1'b1);
    end
    a_resume = 1'b1;
    tick();
    chk_a("a_resume", 32'h31, 1'b1, 1'b0);
    a_resume = 1'b0;
    tick();
    chk_a("a_resume_next", 32'h32, 1'b1, 1'b0);

    // A: all-ones wraps to zero.
    a_branch = 1'b1;
    a_bpc    = 32'hffff_ffff;
    tick();
    a_branch = 1'b0;
    tick();
    chk_a("a_at_ones", 32'hffff_ffff, 1'b1, 1'b0);
    tick();
    chk_a("a_wrap", 32'h0, 1'b1, 1'b0);

    // A: reset asserted mid-bubble takes effect immediately, then boot restarts.
    a_branch = 1'b1;
    a_bpc    = 32'h44;
    tick();
    a_branch = 1'b0;
    chk_a("a_bub44", 32'h44, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_a("a_rst_async", 32'h10, 1'b0, 1'b0);
    tick();
    chk_a("a_rst_held", 32'h10, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_a("a_reboot1", 32'h10, 1'b0, 1'b0);
    tick();
    chk_a("a_reboot_first", 32'h10, 1'b1, 1'b0);
    tick();
    chk_a("a_reboot_next", 32'h11, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
